sam_mem_arbiter: RTL and testbench

- Shares the single 64x8 synchronous program/data memory between two requesters.
- Requester 0 is the SAM CPU bus: ALE-multiplexed address, En/Rw strobes, split data.
- Requester 1 is the console/loader port: req/ack handshake, used to load programs and inspect memory while paused.
- Sits between Toplevel/CPU, console logic and the memory array; owns all memory strobes.

---
 rtl/sam_pkg.sv | 9 +
 rtl/sam_rr_arbiter.sv | 24 ++
 rtl/sam_mem_arbiter.sv | 94 +++++++++
 tb/tb_sam_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sam_pkg.sv
// sam_pkg: shared constants and types for the SAM memory arbiter
package sam_pkg;
    localparam int SAM_ADDR_W    = 8;
    localparam int SAM_DATA_W    = 8;
    localparam int SAM_MEM_DEPTH = 64;
    localparam int SAM_MEM_AW    = 6;
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;
    typedef enum logic {REQ_CPU = 1'b0, REQ_CON = 1'b1} req_id_e;
endpackage

// File: rtl/sam_rr_arbiter.sv
// sam_rr_arbiter: 2-way round-robin grant between CPU and console, remembers last winner
module sam_rr_arbiter
    import sam_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    cpu_req_i,
    input  logic    con_req_i,
    input  logic    take_i,
    output logic    gnt_valid_o,
    output req_id_e gnt_id_o
);
    req_id_e last_q, last_d;
    always_comb begin
        gnt_valid_o = cpu_req_i | con_req_i;
        gnt_id_o    = (cpu_req_i && con_req_i) ? ((last_q == REQ_CPU) ? REQ_CON : REQ_CPU)
                    : (cpu_req_i ? REQ_CPU : REQ_CON);
        last_d      = (take_i && gnt_valid_o) ? gnt_id_o : last_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) last_q <= REQ_CON;
        else         last_q <= last_d;
    end
endmodule

// File: rtl/sam_mem_arbiter.sv
// sam_mem_arbiter: shares the 64x8 program/data memory between the CPU bus and the console port
module sam_mem_arbiter
    import sam_pkg::*;
#(
    parameter int ADDR_W    = SAM_ADDR_W,
    parameter int MEM_DEPTH = SAM_MEM_DEPTH,
    parameter int DATA_W    = SAM_DATA_W
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cpu_ale_i,
    input  logic                  cpu_en_i,
    input  logic                  cpu_rw_i,
    input  logic [ADDR_W-1:0]     cpu_addr_i,
    input  logic [DATA_W-1:0]     cpu_wdata_i,
    output logic [DATA_W-1:0]     cpu_rdata_o,
    output logic                  cpu_rdy_o,
    input  logic                  pause_i,
    input  logic                  con_req_i,
    input  logic                  con_rw_i,
    input  logic [ADDR_W-1:0]     con_addr_i,
    input  logic [DATA_W-1:0]     con_wdata_i,
    output logic [DATA_W-1:0]     con_rdata_o,
    output logic                  con_ack_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [SAM_MEM_AW-1:0] mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    input  logic [DATA_W-1:0]     mem_rdata_i,
    output logic                  addr_err_o
);
    state_e              state_q, state_d;
    req_id_e             id_q, gnt_id;
    logic                gnt_any, grant, acc, resp, in_rng;
    logic                rw_q, err_q, cpu_rdy_q, con_ack_q;
    logic [ADDR_W-1:0]   ale_q, addr_q;
    logic [DATA_W-1:0]   wdata_q, cpu_rdata_q, con_rdata_q, rd_data;
    sam_rr_arbiter u_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cpu_req_i   (cpu_en_i && !pause_i),
        .con_req_i   (con_req_i),
        .take_i      (state_q == ST_IDLE),
        .gnt_valid_o (gnt_any),
        .gnt_id_o    (gnt_id)
    );
    // Memory strobes are decoded from state so an async reset kills them at once
    always_comb begin
        grant       = (state_q == ST_IDLE) && gnt_any;
        acc         = state_q == ST_ACCESS;
        resp        = state_q == ST_RESP;
        in_rng      = 32'(addr_q) < MEM_DEPTH;
        state_d     = grant ? ST_ACCESS : (acc ? ST_RESP : ST_IDLE);
        mem_en_o    = acc && in_rng;
        mem_we_o    = acc && in_rng && !rw_q;
        mem_addr_o  = acc ? addr_q[SAM_MEM_AW-1:0] : '0;
        mem_wdata_o = acc ? wdata_q : '0;
        rd_data     = in_rng ? mem_rdata_i : '0;
        cpu_rdata_o = cpu_rdata_q;
        con_rdata_o = con_rdata_q;
        cpu_rdy_o   = cpu_rdy_q;
        con_ack_o   = con_ack_q;
        addr_err_o  = err_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            ale_q       <= '0;
            id_q        <= REQ_CPU;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            cpu_rdy_q   <= 1'b0;
            con_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            con_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (cpu_ale_i) ale_q <= cpu_addr_i;
            if (grant) begin
                id_q    <= gnt_id;
                rw_q    <= (gnt_id == REQ_CPU) ? cpu_rw_i : con_rw_i;
                addr_q  <= (gnt_id == REQ_CPU) ? ale_q : con_addr_i;
                wdata_q <= (gnt_id == REQ_CPU) ? cpu_wdata_i : con_wdata_i;
            end
            if (acc && !in_rng) err_q <= 1'b1;
            cpu_rdy_q <= resp && id_q == REQ_CPU;
            con_ack_q <= resp && id_q == REQ_CON;
            if (resp && rw_q && id_q == REQ_CPU) cpu_rdata_q <= rd_data;
            if (resp && rw_q && id_q == REQ_CON) con_rdata_q <= rd_data;
        end
    end
endmodule

// File: tb/tb_sam_mem_arbiter.sv
// tb_sam_mem_arbiter: randomized and directed checks of the memory arbiter against a transaction-level model
module tb_sam_mem_arbiter;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       cpu_ale = 0, cpu_en = 0, cpu_rw = 0, pause = 0, con_req = 0, con_rw = 0;
    logic [7:0] cpu_addr = 0, cpu_wdata = 0, con_addr = 0, con_wdata = 0;
    logic [7:0] cpu_rdata, con_rdata, mem_wdata, mem_rdata = 0;
    logic       cpu_rdy, con_ack, mem_en, mem_we, addr_err;
    logic [5:0] mem_addr;
    logic [7:0] mem [64];
    logic [7:0] ref_mem [64];
    logic       pre_we = 0;
    logic [5:0] pre_addr = 0;
    logic [7:0] pre_data = 0;
    logic       err_exp = 0;
    int         n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    sam_mem_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_ale_i(cpu_ale), .cpu_en_i(cpu_en), .cpu_rw_i(cpu_rw), .cpu_addr_i(cpu_addr),
        .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_rdy_o(cpu_rdy), .pause_i(pause),
        .con_req_i(con_req), .con_rw_i(con_rw), .con_addr_i(con_addr), .con_wdata_i(con_wdata),
        .con_rdata_o(con_rdata), .con_ack_o(con_ack), .mem_en_o(mem_en), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .addr_err_o(addr_err)
    );

    // External synchronous 64x8 memory, with a backdoor port for preloading
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic preload(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we = 1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 0;
        ref_mem[a] = d;
    endtask

    // Runs one access from a single requester; returns what was observed on the bus
    task automatic access(input bit who, input bit rw, input logic [7:0] a, input logic [7:0] wd,
                          output int lat, output int en_cnt, output logic [7:0] ea, output logic we,
                          output logic [7:0] ewd, output logic [7:0] rd, output bit other);
        lat = 99; en_cnt = 0; ea = 0; we = 0; ewd = 0; rd = 0; other = 0;
        if (!who) begin
            cpu_ale = 1; cpu_addr = a;
            @(negedge clk);
            cpu_ale = 0; cpu_addr = 8'($urandom); cpu_rw = rw; cpu_wdata = wd; cpu_en = 1;
        end else begin
            con_rw = rw; con_addr = a; con_wdata = wd; con_req = 1;
        end
        for (int k = 1; k <= 10 && lat == 99; k++) begin
            @(negedge clk);
            if (k == 1) begin
                con_addr = 8'($urandom); con_wdata = 8'($urandom); cpu_wdata = 8'($urandom);
                cpu_addr = 8'($urandom); cpu_rw = ~cpu_rw; con_rw = ~con_rw;
            end
            if (mem_en) begin en_cnt++; ea = {2'b00, mem_addr}; we = mem_we; ewd = mem_wdata; end
            if (who ? cpu_rdy : con_ack) other = 1;
            if (who ? con_ack : cpu_rdy) begin
                lat = k; rd = who ? con_rdata : cpu_rdata; cpu_en = 0; con_req = 0;
            end
        end
        cpu_en = 0; con_req = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 64; i++) preload(6'(i), 8'($urandom));
        n_chk++;
        if ({cpu_rdata, con_rdata, cpu_rdy, con_ack, mem_en, mem_we, mem_addr, mem_wdata, addr_err} !== '0)
            $display("FAIL reset_outputs: got %h want 0",
                     {cpu_rdata, con_rdata, cpu_rdy, con_ack, mem_en, mem_we, mem_addr, mem_wdata, addr_err});
        else n_pass++;
        rst_n = 1;
        @(negedge clk);
        n_chk++;
        if ({mem_en, cpu_rdy, con_ack} !== 3'b000) $display("FAIL idle_after_reset: got %b want 000", {mem_en, cpu_rdy, con_ack});
        else n_pass++;
    endtask

    task automatic test_cpu_read();
        int lat, ec; logic [7:0] ea, ewd, rd; logic we; bit oth;
        preload(19, 8'h63);
        access(0, 1, 8'd19, 8'h00, lat, ec, ea, we, ewd, rd, oth);
        n_chk++; if (lat !== 3) $display("FAIL cpu_read_latency: got %0d want 3", lat); else n_pass++;
        n_chk++; if (ec !== 1 || ea !== 8'd19 || we !== 0) $display("FAIL cpu_read_strobe: got en=%0d addr=%0d we=%b want 1/19/0", ec, ea, we); else n_pass++;
        n_chk++; if (rd !== 8'h63) $display("FAIL cpu_read_data: got %h want 63", rd); else n_pass++;
        n_chk++; if (oth !== 0) $display("FAIL cpu_read_no_ack: got con_ack pulse want none"); else n_pass++;
    endtask

    task automatic test_cpu_write();
        int lat, ec; logic [7:0] ea, ewd, rd; logic we; bit oth;
        access(0, 0, 8'd4, 8'h01, lat, ec, ea, we, ewd, rd, oth);
        ref_mem[4] = 8'h01;
        n_chk++; if (lat !== 3) $display("FAIL cpu_write_latency: got %0d want 3", lat); else n_pass++;
        n_chk++;
        if (ec !== 1 || we !== 1 || ea !== 8'd4 || ewd !== 8'h01)
            $display("FAIL cpu_write_strobe: got en=%0d we=%b addr=%0d wd=%h want 1/1/4/01", ec, we, ea, ewd);
        else n_pass++;
        access(0, 1, 8'd4, 8'h00, lat, ec, ea, we, ewd, rd, oth);
        n_chk++; if (rd !== 8'h01) $display("FAIL cpu_write_readback: got %h want 01", rd); else n_pass++;
    endtask

    task automatic test_random();
        int lat, ec; logic [7:0] ea, ewd, rd, a, wd; logic we; bit oth, who, rw, ok;
        for (int i = 0; i < 24; i++) begin
            who = 1'($urandom); rw = 1'($urandom); wd = 8'($urandom);
            a = ($urandom % 5 == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63));
            ok = a < 8'd64;
            access(who, rw, a, wd, lat, ec, ea, we, ewd, rd, oth);
            if (!ok) err_exp = 1;
            n_chk++;
            if (lat !== 3 || ec !== int'(ok) || oth !== 0)
                $display("FAIL rand_timing[%0d]: got lat=%0d en=%0d other=%b want 3/%0d/0", i, lat, ec, oth, ok);
            else n_pass++;
            n_chk++;
            if (rw && rd !== (ok ? ref_mem[a[5:0]] : 8'h00))
                $display("FAIL rand_read[%0d]: addr=%h got %h want %h", i, a, rd, ok ? ref_mem[a[5:0]] : 8'h00);
            else if (!rw && ok && (we !== 1 || ea !== a || ewd !== wd))
                $display("FAIL rand_write[%0d]: got we=%b addr=%h wd=%h want 1/%h/%h", i, we, ea, ewd, a, wd);
            else n_pass++;
            n_chk++;
            if (addr_err !== err_exp) $display("FAIL rand_addr_err[%0d]: got %b want %b", i, addr_err, err_exp); else n_pass++;
            if (!rw && ok) ref_mem[a[5:0]] = wd;
        end
    endtask

    task automatic test_out_of_range();
        int lat, ec; logic [7:0] ea, ewd, rd; logic we; bit oth;
        access(0, 1, 8'd19, 8'h00, lat, ec, ea, we, ewd, rd, oth);
        access(0, 1, 8'h40, 8'h00, lat, ec, ea, we, ewd, rd, oth);
        n_chk++; if (ec !== 0 || lat !== 3) $display("FAIL oor_strobe: got en=%0d lat=%0d want 0/3", ec, lat); else n_pass++;
        n_chk++; if (rd !== 8'h00) $display("FAIL oor_rdata: got %h want 00", rd); else n_pass++;
        n_chk++; if (addr_err !== 1) $display("FAIL oor_err_set: got %b want 1", addr_err); else n_pass++;
        access(1, 1, 8'd3, 8'h00, lat, ec, ea, we, ewd, rd, oth);
        n_chk++; if (addr_err !== 1 || rd !== ref_mem[3]) $display("FAIL oor_err_sticky: got err=%b rd=%h want 1/%h", addr_err, rd, ref_mem[3]); else n_pass++;
    endtask

    task automatic test_pause();
        int acks = 0, rdys = 0, gk = 99, bad = 0; logic [7:0] rd = 0;
        cpu_ale = 1; cpu_addr = 8'd5; pause = 1;
        @(negedge clk);
        cpu_ale = 0; cpu_rw = 1; cpu_en = 1; con_req = 1; con_rw = 0; con_addr = 8'd8; con_wdata = 8'h17;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            acks += int'(con_ack); rdys += int'(cpu_rdy);
            if (mem_en && (mem_addr !== 6'd8 || !mem_we)) bad++;
        end
        con_req = 0; pause = 0;
        ref_mem[8] = 8'h17;
        n_chk++; if (acks !== 4 || bad !== 0) $display("FAIL pause_con_writes: got acks=%0d bad=%0d want 4/0", acks, bad); else n_pass++;
        n_chk++; if (rdys !== 0) $display("FAIL pause_cpu_blocked: got %0d rdy want 0", rdys); else n_pass++;
        n_chk++; if (mem[8] !== 8'h17) $display("FAIL pause_mem8: got %h want 17", mem[8]); else n_pass++;
        for (int k = 1; k <= 8 && cpu_en; k++) begin
            @(negedge clk);
            if (mem_en && mem_addr == 6'd5 && gk == 99) gk = k;
            if (cpu_rdy) begin rd = cpu_rdata; cpu_en = 0; end
        end
        cpu_en = 0;
        n_chk++; if (gk > 3) $display("FAIL pause_release_grant: got %0d cycles want <=3", gk); else n_pass++;
        n_chk++; if (rd !== ref_mem[5]) $display("FAIL pause_release_data: got %h want %h", rd, ref_mem[5]); else n_pass++;
    endtask

    task automatic test_contention();
        bit e_en, e_cpu, e_con; int i;
        rst_n = 0;
        cpu_en = 1; cpu_rw = 1; con_req = 1; con_rw = 1; con_addr = 8'd7; pause = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        // Access i is granted at edge 3i: CPU first after reset, then alternating
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            i = (k - 1) / 3;
            e_en = (k % 3) == 1;
            e_cpu = (k % 3) == 0 && ((k / 3 - 1) % 2) == 0;
            e_con = (k % 3) == 0 && ((k / 3 - 1) % 2) == 1;
            n_chk++;
            if ({mem_en, cpu_rdy, con_ack} !== {e_en, e_cpu, e_con})
                $display("FAIL contention[%0d]: got en/rdy/ack=%b want %b", k, {mem_en, cpu_rdy, con_ack}, {e_en, e_cpu, e_con});
            else if (e_en && mem_addr !== ((i % 2 == 0) ? 6'd0 : 6'd7))
                $display("FAIL contention_addr[%0d]: got %0d want %0d", k, mem_addr, (i % 2 == 0) ? 0 : 7);
            else if ((e_cpu && cpu_rdata !== ref_mem[0]) || (e_con && con_rdata !== ref_mem[7]))
                $display("FAIL contention_data[%0d]: got cpu=%h con=%h want %h/%h", k, cpu_rdata, con_rdata, ref_mem[0], ref_mem[7]);
            else n_pass++;
        end
        cpu_en = 0; con_req = 0;
        n_chk++; if (addr_err !== 0) $display("FAIL err_cleared_by_reset: got %b want 0", addr_err); else n_pass++;
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        int rdys = 0; logic [5:0] a1 = 0;
        preload(30, 8'h5A);
        cpu_ale = 1; cpu_addr = 8'd30;
        @(negedge clk);
        cpu_ale = 0; cpu_rw = 0; cpu_wdata = 8'hAA; cpu_en = 1;
        @(posedge clk);
        #2;
        n_chk++; if ({mem_en, mem_we} !== 2'b11) $display("FAIL mid_access_strobe: got %b want 11", {mem_en, mem_we}); else n_pass++;
        #1 rst_n = 0;
        #1;
        n_chk++; if ({mem_en, mem_we} !== 2'b00) $display("FAIL async_reset_strobe: got %b want 00", {mem_en, mem_we}); else n_pass++;
        cpu_en = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin @(negedge clk); rdys += int'(cpu_rdy); end
        n_chk++; if (rdys !== 0) $display("FAIL abandoned_no_rdy: got %0d want 0", rdys); else n_pass++;
        n_chk++; if (mem[30] !== 8'h5A) $display("FAIL abandoned_word: got %h want 5a", mem[30]); else n_pass++;
        cpu_rw = 1; cpu_en = 1; con_req = 1; con_rw = 1; con_addr = 8'd9;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) a1 = mem_addr;
        end
        n_chk++; if (a1 !== 6'd0) $display("FAIL latch_reset_addr: got %0d want 0", a1); else n_pass++;
        n_chk++;
        if ({cpu_rdy, con_ack} !== 2'b10 || cpu_rdata !== ref_mem[0])
            $display("FAIL first_tie_cpu: got rdy/ack=%b data=%h want 10/%h", {cpu_rdy, con_ack}, cpu_rdata, ref_mem[0]);
        else n_pass++;
        cpu_en = 0; con_req = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_random();
        test_out_of_range();
        test_pause();
        test_contention();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
